// File: rtl/occ_rx_link_monitor_if.sv
// PHY receive-side bundle between the GTP receive path, the link monitor
// and the downstream frame decoder.
interface occ_rx_link_monitor_if;
  logic        rx_rdy_i;
  logic [15:0] rx_data_i;
  logic [1:0]  rx_k_i;
  logic        rx_enc_err_i;
  logic        rx_buf_err_i;
  logic        rx_synced_i;
  logic        rx_resync_o;
  logic [15:0] data_o;
  logic [1:0]  k_o;
  logic        valid_o;
  logic        link_up_o;
  logic [15:0] err_cnt_o;
  logic [7:0]  resync_cnt_o;

  // PHY / stimulus side
  modport master (
    output rx_rdy_i, rx_data_i, rx_k_i, rx_enc_err_i, rx_buf_err_i, rx_synced_i,
    input  rx_resync_o, data_o, k_o, valid_o, link_up_o, err_cnt_o, resync_cnt_o
  );

  // Link monitor side
  modport slave (
    input  rx_rdy_i, rx_data_i, rx_k_i, rx_enc_err_i, rx_buf_err_i, rx_synced_i,
    output rx_resync_o, data_o, k_o, valid_o, link_up_o, err_cnt_o, resync_cnt_o
  );
endinterface

// File: rtl/occ_rx_link_monitor.sv
// OCC receive link monitor: qualifies the link from consecutive IDLE words,
// drives PHY resync requests, forwards payload words and keeps statistics.
module occ_rx_link_monitor #(
  parameter logic [15:0] g_IDLE          = 16'h95bc,
  parameter logic [1:0]  g_IDLE_K        = 2'b01,
  parameter int unsigned g_NUM_IDLE_LOCK = 16,
  parameter int unsigned g_MAX_ERR       = 4,
  parameter int unsigned g_ERR_WINDOW    = 256,
  parameter int unsigned g_RESYNC_PULSE  = 4,
  parameter int unsigned g_SYNC_TIMEOUT  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  occ_rx_link_monitor_if.slave  bus
);

  localparam int unsigned LOCK_W  = $clog2(g_NUM_IDLE_LOCK + 1);
  localparam int unsigned WERR_W  = $clog2(g_MAX_ERR + 1);
  localparam int unsigned WIN_W   = $clog2(g_ERR_WINDOW + 1);
  localparam int unsigned PULSE_W = $clog2(g_RESYNC_PULSE + 1);
  localparam int unsigned TO_W    = $clog2(g_SYNC_TIMEOUT + 1);

  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(g_NUM_IDLE_LOCK - 1);
  localparam logic [WERR_W-1:0]  WERR_MAX   = WERR_W'(g_MAX_ERR);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(g_ERR_WINDOW - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(g_RESYNC_PULSE - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(g_SYNC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_DOWN,
    ST_RESYNC,
    ST_WAIT_SYNC,
    ST_HUNT,
    ST_UP
  } state_t;

  state_t              state;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [WERR_W-1:0]   win_err;
  logic [WIN_W-1:0]    win_cnt;
  logic [PULSE_W-1:0]  pulse_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [15:0]         err_cnt;
  logic [7:0]          resync_cnt;

  logic                err;
  logic                idle_word;
  logic                idle;
  logic                win_wrap;
  logic [WERR_W-1:0]   win_err_nxt;
  logic                err_trip;
  logic [15:0]         err_cnt_inc;
  logic [7:0]          resync_cnt_inc;

  // Word classification, window bookkeeping and saturating increments
  always_comb begin
    err            = bus.rx_enc_err_i | bus.rx_buf_err_i;
    idle_word      = (bus.rx_data_i == g_IDLE) && (bus.rx_k_i == g_IDLE_K);
    idle           = idle_word && !err;
    win_wrap       = (win_cnt == WIN_LAST);
    // an error on the wrap cycle is the first error of the new window
    win_err_nxt    = (win_wrap ? '0 : win_err) + WERR_W'(err);
    err_trip       = err && (win_err_nxt == WERR_MAX);
    err_cnt_inc    = (err_cnt == '1) ? err_cnt : err_cnt + 16'd1;
    resync_cnt_inc = (resync_cnt == '1) ? resync_cnt : resync_cnt + 8'd1;
  end

  // Link FSM with registered outputs, counters and 1-cycle datapath
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= ST_DOWN;
      lock_cnt         <= '0;
      win_err          <= '0;
      win_cnt          <= '0;
      pulse_cnt        <= '0;
      to_cnt           <= '0;
      err_cnt          <= '0;
      resync_cnt       <= '0;
      bus.rx_resync_o  <= 1'b0;
      bus.data_o       <= '0;
      bus.k_o          <= '0;
      bus.valid_o      <= 1'b0;
      bus.link_up_o    <= 1'b0;
    end else begin
      bus.data_o  <= bus.rx_data_i;
      bus.k_o     <= bus.rx_k_i;
      bus.valid_o <= (state == ST_UP) && !err && !idle_word;

      if (!bus.rx_rdy_i) begin
        state           <= ST_DOWN;
        bus.rx_resync_o <= 1'b0;
        bus.link_up_o   <= 1'b0;
      end else begin
        case (state)
          ST_DOWN: begin
            state           <= ST_RESYNC;
            bus.rx_resync_o <= 1'b1;
            pulse_cnt       <= '0;
            resync_cnt      <= resync_cnt_inc;
          end

          ST_RESYNC: begin
            if (pulse_cnt == PULSE_LAST) begin
              state           <= ST_WAIT_SYNC;
              bus.rx_resync_o <= 1'b0;
              to_cnt          <= '0;
            end else begin
              pulse_cnt <= pulse_cnt + 1'b1;
            end
          end

          ST_WAIT_SYNC: begin
            if (bus.rx_synced_i) begin
              state    <= ST_HUNT;
              lock_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
              state           <= ST_RESYNC;
              bus.rx_resync_o <= 1'b1;
              pulse_cnt       <= '0;
              resync_cnt      <= resync_cnt_inc;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end

          ST_HUNT: begin
            if (!bus.rx_synced_i) begin
              state           <= ST_RESYNC;
              bus.rx_resync_o <= 1'b1;
              pulse_cnt       <= '0;
              resync_cnt      <= resync_cnt_inc;
            end else if (idle) begin
              if (lock_cnt == LOCK_LAST) begin
                state         <= ST_UP;
                bus.link_up_o <= 1'b1;
                win_cnt       <= '0;
                win_err       <= '0;
              end else begin
                lock_cnt <= lock_cnt + 1'b1;
              end
            end else begin
              lock_cnt <= '0;
            end
          end

          ST_UP: begin
            if (err) begin
              err_cnt <= err_cnt_inc;
            end
            win_err <= win_err_nxt;
            win_cnt <= win_wrap ? '0 : win_cnt + 1'b1;
            // sync loss and error threshold together still give one entry
            if (!bus.rx_synced_i || err_trip) begin
              state           <= ST_RESYNC;
              bus.link_up_o   <= 1'b0;
              bus.rx_resync_o <= 1'b1;
              pulse_cnt       <= '0;
              resync_cnt      <= resync_cnt_inc;
            end
          end

          default: begin
            state           <= ST_DOWN;
            bus.rx_resync_o <= 1'b0;
            bus.link_up_o   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.err_cnt_o    = err_cnt;
  assign bus.resync_cnt_o = resync_cnt;

endmodule

// File: doc/occ_rx_link_monitor.md
Name: occ_rx_link_monitor

Overview:
- Sits directly downstream of the OCC GTP PHY receive path, in the PHY rx_clk_o domain.
- Consumes the PHY receive word stream and status. Drives the PHY resync request.
- Qualifies the link by counting consecutive IDLE words, and declares it up or down.
- Forwards non-IDLE payload words with a valid strobe to the frame decoder, and keeps saturating error and resync statistics.

Parameters:
- g_IDLE, 16'h95bc, IDLE word value.
- g_IDLE_K, 2'b01, K-flags of the IDLE word.
- g_NUM_IDLE_LOCK, 16, consecutive error-free IDLE words required to declare link up (must be ≥1).
- g_MAX_ERR, 4, errors within one window that force link down (must be ≥1).
- g_ERR_WINDOW, 256, error-window length in clk_i cycles.
- g_RESYNC_PULSE, 4, rx_resync_o pulse width in cycles.
- g_SYNC_TIMEOUT, 1024, cycles to wait for rx_synced_i before re-requesting resync.

Ports:
- clk_i  in  1  PHY receive clock (rx_clk_o).
- rst_i  in  1  asynchronous active-high reset.
- rx_rdy_i  in  1  PHY receiver ready.
- rx_data_i  in  16  PHY receive data.
- rx_k_i  in  2  PHY K-flags.
- rx_enc_err_i  in  1  8b10b decode error.
- rx_buf_err_i  in  1  elastic buffer error.
- rx_synced_i  in  1  PHY comma alignment done.
- rx_resync_o  out  1  resync request to PHY.
- data_o  out  16  forwarded payload word.
- k_o  out  2  forwarded K-flags.
- valid_o  out  1  data_o/k_o valid.
- link_up_o  out  1  link qualified.
- err_cnt_o  out  16  saturating total error count (UP state only).
- resync_cnt_o  out  8  saturating count of RESYNC entries.

Behaviour:
- Reset: one clock (clk_i); reset is asynchronous and active-high.
  - All outputs are 0, all counters are 0, and the FSM is in DOWN.
- Definitions:
  - err = rx_enc_err_i | rx_buf_err_i.
  - idle = (rx_data_i == g_IDLE) & (rx_k_i == g_IDLE_K) & !err.
- FSM, global override: if rx_rdy_i=0, the FSM goes to DOWN the next cycle from any state (highest priority).
- DOWN:
  - link_up_o=0.
  - rx_rdy_i=1 → RESYNC.
- RESYNC:
  - Increment resync_cnt_o (saturate at 255).
  - Hold rx_resync_o=1 for exactly g_RESYNC_PULSE cycles, then go to WAIT_SYNC.
- WAIT_SYNC:
  - rx_resync_o=0 and the timeout counter runs.
  - rx_synced_i=1 → HUNT.
  - g_SYNC_TIMEOUT cycles without rx_synced_i → RESYNC.
- HUNT:
  - An idle word increments the lock counter. Any non-idle word or err clears it to 0.
  - When the counter reaches g_NUM_IDLE_LOCK → UP.
  - rx_synced_i=0 → RESYNC.
- UP:
  - link_up_o=1, registered: it rises on the cycle after the g_NUM_IDLE_LOCK-th idle is sampled.
  - Each cycle with err increments err_cnt_o (saturate at 16'hFFFF) and the window error count.
  - Window error count reaching g_MAX_ERR → RESYNC.
  - rx_synced_i=0 → RESYNC.
  - Leaving UP drops link_up_o on the next cycle.
- Error window:
  - A free-running counter in UP, restarted on UP entry, wraps every g_ERR_WINDOW cycles.
  - On wrap, the window error count is cleared. An err on the wrap cycle counts as 1 in the new window.
- Datapath: 1-cycle registered latency.
  - valid_o=1 iff the state is UP, !err, and the word is not (g_IDLE with g_IDLE_K).
  - data_o/k_o are registered from rx_data_i/rx_k_i every cycle, regardless of valid.
  - Valid is never asserted outside UP, including on the cycle an error-triggered exit is taken.
- Simultaneous events:
  - rx_rdy_i low beats everything.
  - In UP, a rx_synced_i drop and reaching the error threshold in the same cycle give a single RESYNC entry (resync_cnt_o +1).
- Counters:
  - err_cnt_o and resync_cnt_o clear only on rst_i, never on state changes.

Test Plan:
- Reset, then rx_rdy_i=1 with rx_synced_i tied 1 → rx_resync_o high for exactly 4 cycles; resync_cnt_o=1; after 16 IDLE words (16'h95bc, K=01), link_up_o=1 on the following cycle.
- In HUNT, send 10 IDLE, 1 word 16'h1234, then 16 IDLE → link_up_o rises only after the final 16 IDLE words (27 words total from HUNT entry).
- In UP, send IDLE, 16'hA5A5 K=00, IDLE, 16'h0001 K=00 → valid_o pulses exactly twice, one cycle after each payload word, with data_o=16'hA5A5 then 16'h0001.
- In UP, assert rx_enc_err_i on 4 cycles within 256 cycles → link_up_o drops, resync_cnt_o=2, err_cnt_o=4.
  - Repeat with the 4 errors spread at cycles 0, 100, 300, 400 after UP entry → link stays up; err_cnt_o=8.
- Hold rx_synced_i=0 in WAIT_SYNC for 1024 cycles → new 4-cycle rx_resync_o pulse; resync_cnt_o increments.
- In UP, deassert rx_rdy_i → state is DOWN and link_up_o=0 within 2 cycles.
  - Assert rst_i mid-UP → all outputs 0 immediately (asynchronous), with no clock edge required.
